// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 16-bit words and streams them into program memory.
// Optional feature macro: CHECKSUM_EN appends an XOR checksum word after the last instruction.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        cond,
  input  logic [3:0]        opcode,
  input  logic [2:0]        reg_dest,
  input  logic [2:0]        reg_1,
  input  logic [2:0]        reg_2,
  input  logic              shift_bit,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned       WORD_W    = 16;
  localparam int unsigned       CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

`ifdef CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   ptr_d;
  logic                in_ready_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [WORD_W-1:0]   mem_wdata_q;
  logic                busy_q;
  logic                done_q;
  logic                overflow_q;
  logic [CNT_W-1:0]    word_count_q;
`ifdef CHECKSUM_EN
  logic [WORD_W-1:0]   csum_q;
`endif

  logic [WORD_W-1:0]   enc_word;
  logic                xfer;
  logic                at_end;

  // Field packing, transfer qualifier and saturating pointer advance.
  always_comb begin
    enc_word = {cond, opcode, reg_dest, reg_1, reg_2, shift_bit};
    xfer     = in_valid & in_ready_q;
    at_end   = (ptr_q == LAST_ADDR);
    ptr_d    = at_end ? ptr_q : ptr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
`ifdef CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ptr_q        <= start_addr;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
`ifdef CHECKSUM_EN
            csum_q       <= '0;
`endif
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= ptr_q;
            mem_wdata_q  <= enc_word;
            ptr_q        <= ptr_d;
            word_count_q <= word_count_q + CNT_W'(1);
`ifdef CHECKSUM_EN
            csum_q       <= csum_q ^ enc_word;
`endif
            // Session ends on the flagged word or when the top address is consumed.
            if (in_last) begin
              in_ready_q <= 1'b0;
`ifdef CHECKSUM_EN
              if (at_end) begin
                overflow_q <= 1'b1;
                state_q    <= S_DONE;
              end else begin
                state_q    <= S_CSUM;
              end
`else
              state_q    <= S_DONE;
`endif
            end else if (at_end) begin
              in_ready_q <= 1'b0;
              overflow_q <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end
`ifdef CHECKSUM_EN
        S_CSUM: begin
          mem_we_q     <= 1'b1;
          mem_addr_q   <= ptr_q;
          mem_wdata_q  <= csum_q;
          ptr_q        <= ptr_d;
          word_count_q <= word_count_q + CNT_W'(1);
          state_q      <= S_DONE;
        end
`endif
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: randomized field sets against a session-level model.
module tb_instr_encoder_loader;

  localparam int unsigned ADDR_W = 4;
  localparam int          DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [1:0]        cond;
  logic [3:0]        opcode;
  logic [2:0]        reg_dest;
  logic [2:0]        reg_1;
  logic [2:0]        reg_2;
  logic              shift_bit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;

  instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .cond(cond), .opcode(opcode), .reg_dest(reg_dest), .reg_1(reg_1),
    .reg_2(reg_2), .shift_bit(shift_bit), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .overflow(overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] c;
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] r1;
    logic [2:0] r2;
    logic       sh;
    logic       last;
  } set_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    int unsigned       cyc;
  } wr_t;

  typedef struct {
    int unsigned cyc;
    int          wc;
    bit          ovf;
  } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    total = 0;
  int    bad   = 0;

  // Session model state
  logic [ADDR_W-1:0] m_sa;
  int                m_idx;
  bit                m_open;
  logic [15:0]       m_xor;

  function automatic logic [15:0] model_enc(input set_t s);
    int v;
    v = int'(s.c) * 16384 + int'(s.op) * 1024 + int'(s.rd) * 128 +
        int'(s.r1) * 16 + int'(s.r2) * 2 + int'(s.sh);
    return v[15:0];
  endfunction

  function automatic set_t rand_set(input bit last);
    set_t s;
    s.c    = 2'($urandom_range(3));
    s.op   = 4'($urandom_range(15));
    s.rd   = 3'($urandom_range(7));
    s.r1   = 3'($urandom_range(7));
    s.r2   = 3'($urandom_range(7));
    s.sh   = 1'($urandom_range(1));
    s.last = last;
    return s;
  endfunction

  // Monitor: every write strobe and done pulse must match the head of its queue.
  wr_t   got_w;
  done_t got_d;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h", cyc, mem_addr, mem_wdata);
      end else begin
        got_w = exp_wr.pop_front();
        if (mem_addr !== got_w.addr || mem_wdata !== got_w.data || cyc != got_w.cyc) begin
          bad++;
          $display("FAIL write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                   mem_addr, mem_wdata, cyc, got_w.addr, got_w.data, got_w.cyc);
        end
      end
    end
    if (done === 1'b1) begin
      total++;
      if (exp_done.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done cyc=%0d", cyc);
      end else begin
        got_d = exp_done.pop_front();
        if (cyc != got_d.cyc || int'(word_count) != got_d.wc || overflow !== got_d.ovf) begin
          bad++;
          $display("FAIL done got cyc=%0d wc=%0d ovf=%b want cyc=%0d wc=%0d ovf=%b",
                   cyc, word_count, overflow, got_d.cyc, got_d.wc, got_d.ovf);
        end
      end
    end
  end

  task automatic drive_set(input set_t s);
    cond = s.c; opcode = s.op; reg_dest = s.rd; reg_1 = s.r1; reg_2 = s.r2;
    shift_bit = s.sh; in_last = s.last;
  endtask

  task automatic idle_inputs();
    start = 1'b0; start_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    cond = '0; opcode = '0; reg_dest = '0; reg_1 = '0; reg_2 = '0; shift_bit = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    total++;
    if ({in_ready, mem_we, busy, done, overflow, mem_addr, mem_wdata, word_count} !== '0) begin
      bad++;
      $display("FAIL %s rdy=%b we=%b busy=%b done=%b ovf=%b addr=%0d data=%h wc=%0d want all zero",
               name, in_ready, mem_we, busy, done, overflow, mem_addr, mem_wdata, word_count);
    end
  endtask

  task automatic close_session(input bit ovf, input int wc, input int unsigned dcyc);
    done_t d;
    d.cyc = dcyc; d.wc = wc; d.ovf = ovf;
    exp_done.push_back(d);
    m_open = 1'b0;
  endtask

  // Starts a session; optionally presents the first set alongside start (must not be consumed).
  task automatic begin_session(input logic [ADDR_W-1:0] sa, input bit valid_with_start, input set_t first);
    @(negedge clk);
    start = 1'b1; start_addr = sa;
    if (valid_with_start) begin
      drive_set(first);
      in_valid = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    m_sa = sa; m_idx = 0; m_open = 1'b1; m_xor = '0;
    total++;
    if ({busy, overflow, word_count} !== {1'b1, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL session_start busy=%b ovf=%b wc=%0d want busy=1 ovf=0 wc=0", busy, overflow, word_count);
    end
  endtask

  // Offers one set at the current negedge; checks acceptance against the model.
  task automatic offer(input set_t s, input int gap_pct);
    bit          exp_acc;
    bit          acc;
    int          t;
    int          a;
    int          lim;
    wr_t         w;
    logic [15:0] enc;
    exp_acc = m_open;
    if ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      start = exp_acc ? 1'($urandom_range(1)) : 1'b0;
      start_addr = ADDR_W'($urandom_range(DEPTH - 1));
      @(negedge clk);
    end
    drive_set(s);
    in_valid = 1'b1;
    start = exp_acc ? 1'($urandom_range(1)) : 1'b0;
    start_addr = ADDR_W'($urandom_range(DEPTH - 1));
    lim = exp_acc ? 20 : 4;
    t = 0;
    while (in_ready !== 1'b1 && t < lim) begin
      @(negedge clk);
      t++;
    end
    acc = (in_ready === 1'b1);
    total++;
    if (acc != exp_acc) begin
      bad++;
      $display("FAIL accept got=%b want=%b", acc, exp_acc);
    end
    if (acc && exp_acc) begin
      enc = model_enc(s);
      a = int'(m_sa) + m_idx;
      w.addr = ADDR_W'(a); w.data = enc; w.cyc = cyc + 1;
      exp_wr.push_back(w);
      m_xor = m_xor ^ enc;
      m_idx++;
      if (s.last) begin
`ifdef CHECKSUM_EN
        if (a == DEPTH - 1) begin
          close_session(1'b1, m_idx, cyc + 2);
        end else begin
          w.addr = ADDR_W'(a + 1); w.data = m_xor; w.cyc = cyc + 2;
          exp_wr.push_back(w);
          close_session(1'b0, m_idx + 1, cyc + 3);
        end
`else
        close_session(1'b0, m_idx, cyc + 2);
`endif
      end else if (a == DEPTH - 1) begin
        close_session(1'b1, m_idx, cyc + 2);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0) && t < 20) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (exp_wr.size() != 0 || exp_done.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout writes_left=%0d dones_left=%0d", exp_wr.size(), exp_done.size());
      exp_wr.delete();
      exp_done.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    set_t s;
    set_t none;
    int   n;
    int   li;
    logic [ADDR_W-1:0] sa;
    none = rand_set(1'b0);
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_reset_vals("reset_state");
    reset = 1'b0;
    @(negedge clk);

    // Single set, the documented example word.
    s.c = 2'b01; s.op = 4'b0011; s.rd = 3'd2; s.r1 = 3'd5; s.r2 = 3'd7; s.sh = 1'b1; s.last = 1'b1;
    begin_session(4'd0, 1'b0, none);
    offer(s, 0);
    idle_inputs();
    drain();

    // Back-to-back from address 3, first set also presented alongside start.
    s = rand_set(1'b0);
    begin_session(4'd3, 1'b1, s);
    offer(s, 0);
    for (int i = 0; i < 3; i++) offer(rand_set(i == 2), 0);
    idle_inputs();
    drain();

    // Valid toggling with idle gaps between sets.
    begin_session(4'd7, 1'b0, none);
    for (int i = 0; i < 4; i++) offer(rand_set(i == 3), 100);
    idle_inputs();
    drain();

    // Overflow at the top of memory; third set must be refused.
    begin_session(4'd14, 1'b0, none);
    for (int i = 0; i < 3; i++) offer(rand_set(1'b0), 0);
    idle_inputs();
    drain();

    // Documented pair for the checksum case (plain words when the option is off).
    s.c = 2'b01; s.op = 4'b0011; s.rd = 3'd2; s.r1 = 3'd5; s.r2 = 3'd7; s.sh = 1'b1; s.last = 1'b0;
    begin_session(4'd0, 1'b0, none);
    offer(s, 0);
    s.c = '0; s.op = '0; s.rd = '0; s.r1 = '0; s.r2 = '0; s.sh = 1'b1; s.last = 1'b1;
    offer(s, 0);
    idle_inputs();
    drain();

    // Randomized sessions, including last on the top address.
    for (int k = 0; k < 10; k++) begin
      sa = ADDR_W'($urandom_range(DEPTH - 1));
      n  = $urandom_range(1, 6);
      li = $urandom_range(0, n - 1);
      begin_session(sa, 1'($urandom_range(1)), rand_set(1'b0));
      for (int i = 0; i < n; i++) offer(rand_set(i == li), 40);
      idle_inputs();
      drain();
    end
    begin_session(4'd15, 1'b0, none);
    offer(rand_set(1'b1), 0);
    idle_inputs();
    drain();

    // Reset in the middle of a session with a transfer pending in the reset cycle.
    begin_session(4'd0, 1'b0, none);
    offer(rand_set(1'b0), 0);
    offer(rand_set(1'b0), 0);
    drive_set(rand_set(1'b0));
    in_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_mid_load");
    reset = 1'b0;
    idle_inputs();
    m_open = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_vals("after_abort");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
